// File: rtl/demultiplexer_2_buf_if.sv
// Handshake bundle for the buffered 1-to-2 demultiplexer.
// The master side drives words in and drains both outputs.
interface demultiplexer_2_buf_if #(
    parameter int WIDTH = 32
);
    logic             Enable;
    logic             Sel;
    logic [WIDTH-1:0] DemuxIn;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] DemuxOut_0;
    logic [WIDTH-1:0] DemuxOut_1;
    logic             OutValid_0;
    logic             OutValid_1;
    logic             OutReady_0;
    logic             OutReady_1;
    logic [1:0]       Level_0;
    logic [1:0]       Level_1;

    modport master (
        output Enable,
        output Sel,
        output DemuxIn,
        output InValid,
        input  InReady,
        input  DemuxOut_0,
        input  DemuxOut_1,
        input  OutValid_0,
        input  OutValid_1,
        output OutReady_0,
        output OutReady_1,
        input  Level_0,
        input  Level_1
    );

    modport slave (
        input  Enable,
        input  Sel,
        input  DemuxIn,
        input  InValid,
        output InReady,
        output DemuxOut_0,
        output DemuxOut_1,
        output OutValid_0,
        output OutValid_1,
        input  OutReady_0,
        input  OutReady_1,
        output Level_0,
        output Level_1
    );
endinterface

// File: rtl/demultiplexer_2_buf.sv
// 1-to-2 demultiplexer with an independent 2-entry FIFO per output.
// Words land in the queue chosen by Sel and appear one cycle later.
module demultiplexer_2_buf #(
    parameter int WIDTH = 32
) (
    input logic                 Clock,
    input logic                 nReset,
    demultiplexer_2_buf_if.slave bus
);
    localparam int         DEPTH = 2;
    localparam logic [1:0] FULL  = 2'(DEPTH);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [1:0]       wp;
    logic [1:0]       rp;
    logic [1:0]       cnt [2];

    logic       in_ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;

    assign out_ready = {bus.OutReady_1, bus.OutReady_0};

    always_comb begin
        in_ready = bus.Enable && (cnt[bus.Sel] != FULL);
        push     = 2'b00;
        if (bus.InValid && in_ready)
            push[bus.Sel] = 1'b1;
        for (int k = 0; k < 2; k++)
            pop[k] = (cnt[k] != 2'd0) && out_ready[k];
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wp  <= 2'b00;
            rp  <= 2'b00;
            cnt <= '{default: 2'd0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k])
                    wp[k] <= ~wp[k];
                if (pop[k])
                    rp[k] <= ~rp[k];
                // push+pop together leaves the count unchanged
                unique case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + 2'd1;
                    2'b01:   cnt[k] <= cnt[k] - 2'd1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    // Storage is not reset; it is masked whenever its queue is empty.
    always_ff @(posedge Clock) begin
        for (int k = 0; k < 2; k++)
            if (push[k])
                mem[k][wp[k]] <= bus.DemuxIn;
    end

    assign bus.InReady    = in_ready;
    assign bus.OutValid_0 = (cnt[0] != 2'd0);
    assign bus.OutValid_1 = (cnt[1] != 2'd0);
    assign bus.Level_0    = cnt[0];
    assign bus.Level_1    = cnt[1];
    assign bus.DemuxOut_0 = (cnt[0] != 2'd0) ? mem[0][rp[0]] : '0;
    assign bus.DemuxOut_1 = (cnt[1] != 2'd0) ? mem[1][rp[1]] : '0;
endmodule

// File: tb/tb_demultiplexer_2_buf.sv
// Directed bench for demultiplexer_2_buf with a per-queue scoreboard.
// Expected words are queued on accept and retired on pop.
module tb_demultiplexer_2_buf;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    demultiplexer_2_buf_if #(.WIDTH(32)) bus ();

    demultiplexer_2_buf #(.WIDTH(32)) dut (
        .Clock  (clk),
        .nReset (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input logic en);
        logic [31:0] h0;
        logic [31:0] h1;
        logic        rdy;
        h0  = (q0.size() != 0) ? q0[0] : 32'h0;
        h1  = (q1.size() != 0) ? q1[0] : 32'h0;
        rdy = en && ((bus.Sel ? q1.size() : q0.size()) < 2);
        chk("in_ready",   32'(bus.InReady),    32'(rdy));
        chk("out_valid0", 32'(bus.OutValid_0), 32'(q0.size() != 0));
        chk("out_valid1", 32'(bus.OutValid_1), 32'(q1.size() != 0));
        chk("level0",     32'(bus.Level_0),    32'(q0.size()));
        chk("level1",     32'(bus.Level_1),    32'(q1.size()));
        chk("out0",       bus.DemuxOut_0,      h0);
        chk("out1",       bus.DemuxOut_1,      h1);
    endtask

    // One clock: drive, check pre-edge outputs, then update the model.
    task automatic cycle(input logic en, input logic sel,
                         input logic vld, input logic [31:0] din,
                         input logic r0, input logic r1);
        logic acc;
        logic p0;
        logic p1;
        bus.Enable     = en;
        bus.Sel        = sel;
        bus.InValid    = vld;
        bus.DemuxIn    = din;
        bus.OutReady_0 = r0;
        bus.OutReady_1 = r1;
        #1;
        chk_outputs(en);
        acc = vld && en && ((sel ? q1.size() : q0.size()) < 2);
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (sel) q1.push_back(din);
            else     q0.push_back(din);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.Enable     = 1'b1;
        bus.Sel        = 1'b0;
        bus.InValid    = 1'b0;
        bus.DemuxIn    = 32'h0;
        bus.OutReady_0 = 1'b0;
        bus.OutReady_1 = 1'b0;
        #12;
        chk_outputs(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // single word to queue 0
        cycle(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        idle();
        drain();

        // queue 1 fills, stalls, drains and admits the third word
        cycle(1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drain();

        // full queue 0 does not block queue 1, and is not redirected
        cycle(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'hC1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'hD0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'hC2, 1'b0, 1'b0);
        drain();

        // push and pop together on a one-deep queue
        cycle(1'b1, 1'b0, 1'b1, 32'h5, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h6, 1'b1, 1'b0);
        idle();
        drain();

        // pop on empty queues is ignored
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        idle();

        // Enable low: no accepts, queue 1 drains
        cycle(1'b1, 1'b1, 1'b1, 32'hE1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'hE2, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'hE3, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'hE4, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'hE5, 1'b0, 1'b0);

        // push to one queue while popping the other
        cycle(1'b1, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'hF1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'hF2, 1'b0, 1'b1);
        drain();

        // pseudo-random traffic with pointer wrap
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 7) != 0), 1'($urandom),
                  1'($urandom), $urandom,
                  1'($urandom), 1'($urandom));
        drain();

        // asynchronous reset between edges with both queues full
        cycle(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h101, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h201, 1'b0, 1'b0);
        bus.InValid    = 1'b0;
        bus.OutReady_0 = 1'b1;
        bus.OutReady_1 = 1'b1;
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk_outputs(1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outputs(1'b1);

        // first accept right after reset release
        cycle(1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/demultiplexer_2_buf.md
DEMULTIPLEXER_2_BUF -- requirements
Module: demultiplexer_2_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which is the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, fixed at 2, which is the entries per output queue; DEPTH is not overridable.
REQ-003 Port Clock SHALL be: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 Port nReset SHALL be: input, 1 bit, reset that is asynchronous and active-low.
REQ-005 Port Enable SHALL be: input, 1 bit, which gates acceptance of new words.
REQ-006 Port Sel SHALL be: input, 1 bit, which selects the destination output (0 or 1) for the current input word.
REQ-007 Port DemuxIn SHALL be: input, WIDTH bits, the input data word.
REQ-008 Port InValid SHALL be: input, 1 bit, meaning DemuxIn/Sel are valid this cycle.
REQ-009 Port InReady SHALL be: output, 1 bit, meaning the block accepts the word this cycle.
REQ-010 Ports DemuxOut_0 and DemuxOut_1 SHALL be: outputs, WIDTH bits each, the head word of the respective queue.
REQ-011 Ports OutValid_0 and OutValid_1 SHALL be: outputs, 1 bit each, meaning the respective queue is non-empty.
REQ-012 Ports OutReady_0 and OutReady_1 SHALL be: inputs, 1 bit each, the downstream consume strobes.
REQ-013 Ports Level_0 and Level_1 SHALL be: outputs, 2 bits each, the occupancy of the respective queue (0..2).

Function
REQ-014 The block SHALL keep one independent 2-entry FIFO per output, each with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
REQ-015 InReady SHALL equal Enable AND (count of queue[Sel] < 2); it is combinational and depends on the current Sel.
REQ-016 An accept SHALL occur when InValid AND InReady; the word is written to queue[Sel] at the write pointer, that write pointer toggles, and that count increments.
REQ-017 Sel SHALL be sampled only on an accept cycle; Sel changes on other cycles have no effect.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N is visible on DemuxOut_k with OutValid_k=1 after edge N; there is no same-cycle fall-through.
REQ-019 OutValid_k SHALL equal (count_k != 0), and Level_k SHALL equal count_k.
REQ-020 DemuxOut_k SHALL present the entry at read pointer k when count_k != 0, and all-zeros when count_k == 0.
REQ-021 A pop on queue k SHALL occur when OutValid_k AND OutReady_k; the read pointer toggles and count_k decrements.
REQ-022 OutReady_k asserted while queue k is empty SHALL be ignored: no pointer or count change.
REQ-023 A simultaneous push and pop on the same queue with count 1 SHALL leave count at 1, with the new word becoming head after the old one leaves.
REQ-024 A simultaneous push and pop on the same queue with count 2 SHALL not occur, because InReady=0 when that queue is full; the pop proceeds alone.
REQ-025 A push to one queue and a pop from the other in the same cycle SHALL be handled independently.
REQ-026 With Enable=0, InReady SHALL be 0 and no accepts occur, while both queues continue to drain normally.
REQ-027 Word order within each queue SHALL be strictly preserved; no ordering is implied between the two queues.
REQ-028 Pointers SHALL wrap 1->0 naturally (1-bit), with count never exceeding 2 nor dropping below 0.
REQ-029 A full queue[Sel] SHALL deassert InReady even if the other queue is empty; the block does not redirect the word.

Reset
REQ-030 While nReset=0 (asynchronously), all pointers and counts SHALL be 0, which forces OutValid_0/1=0, Level_0/1=0 and DemuxOut_0/1=0.
REQ-031 Assertion of nReset mid-operation SHALL discard all buffered words, and no pop or push completes on that edge.
REQ-032 InReady SHALL follow REQ-015 during reset (both queues empty, so InReady=Enable).
REQ-033 The first accept SHALL be possible on the first rising Clock edge after nReset deasserts.
REQ-034 Storage contents SHALL not be reset, and are never observable while count=0.

Verification
REQ-035 Scenario: Enable=1, Sel=0, DemuxIn=0xA5A5A5A5, InValid=1 for one cycle, OutReady_0=0 -> next cycle OutValid_0=1, DemuxOut_0=0xA5A5A5A5, Level_0=1, OutValid_1=0, DemuxOut_1=0.
REQ-036 Scenario: push 0x11, 0x22, 0x33 with Sel=1, OutReady_1=0 -> third word stalls with InReady=0 after two accepts, Level_1=2; raise OutReady_1 -> pops 0x11 then 0x22, and 0x33 is accepted on the cycle Level_1 drops to 1.
REQ-037 Scenario: queue 0 full, Sel=1, InValid=1 -> InReady=1 and the word lands in queue 1; switch to Sel=0 -> InReady=0 same cycle.
REQ-038 Scenario: Level_0=1 (head 0x5), push 0x6 to queue 0 with OutReady_0=1 same cycle -> next cycle Level_0=1, DemuxOut_0=0x6.
REQ-039 Scenario: Enable=0, InValid=1, Level_1=2, OutReady_1=1 -> InReady=0, queue 1 drains to 0 in two cycles, no new word enters.
REQ-040 Scenario: both queues holding 2 words, pulse nReset low between edges -> OutValid_0/1=0, Level_0/1=0, DemuxOut_0/1=0 immediately, without waiting for Clock.
